// File: rtl/corelet_seq_pkg.sv
// Shared definitions for the corelet tile sequencer: state encoding and
// instruction-word bit positions.
package corelet_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_K = 3'd1,
    ST_EXEC   = 3'd2,
    ST_FLUSH  = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  localparam int INST_W  = 34;
  localparam int KLOAD   = 0;
  localparam int EXEC    = 1;
  localparam int L0_WR   = 2;
  localparam int L0_RD   = 3;
  localparam int OF_RD   = 6;
  localparam int SFP_ACC = 33;

endpackage

// File: rtl/corelet_seq_counter.sv
// Up-counter with enable and clear; 'last' flags that the next enabled
// increment reaches the terminal count, so no wrap is ever needed.
module seq_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] term,
  output logic             last
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count <= '0;
    else if (clr) count <= '0;
    else if (en)  count <= count + ONE;
  end

  // term is never 0 while the owning phase is active
  assign last = (count == term - ONE);

endmodule

// File: rtl/corelet_seq.sv
// Corelet tile sequencer: kernel load, execute, pipeline flush and OFIFO
// drain, emitting the corelet instruction word each cycle.
module corelet_seq
  import corelet_seq_pkg::*;
#(
  parameter int ROW   = 8,
  parameter int COL   = 8,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [CNT_W-1:0]  num_vec,
  input  logic              acc_en,
  input  logic              l0_o_ready,
  input  logic              l0_o_full,
  input  logic              ofifo_o_valid,
  input  logic              host_valid,
  output logic              host_ready,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] K_TERM = CNT_W'(COL);
  localparam logic [CNT_W-1:0] F_TERM = CNT_W'(ROW + COL);

  state_t           state, state_nx;
  logic             mode_q, acc_q, sfp_q;
  logic [CNT_W-1:0] nv_q;
  logic             k_en, v_en, f_en, d_en, cnt_clr;
  logic             k_last, v_last, f_last, d_last;
  logic             kload, exec_b, l0_rd, of_rd;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      mode_q <= 1'b0;
      acc_q  <= 1'b0;
      nv_q   <= '0;
      sfp_q  <= 1'b0;
    end else begin
      state <= state_nx;
      sfp_q <= of_rd && acc_q;
      // tile parameters only change when a start is accepted in IDLE
      if (state == ST_IDLE && start) begin
        mode_q <= mode;
        acc_q  <= acc_en;
        nv_q   <= num_vec;
      end
    end
  end

  always_comb begin
    state_nx = state;
    kload    = 1'b0;
    exec_b   = 1'b0;
    l0_rd    = 1'b0;
    of_rd    = 1'b0;
    k_en     = 1'b0;
    v_en     = 1'b0;
    f_en     = 1'b0;
    d_en     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          if (num_vec == '0) state_nx = ST_DONE;
          else               state_nx = mode ? ST_EXEC : ST_LOAD_K;
        end
      end
      ST_LOAD_K: begin
        l0_rd = l0_o_ready;
        kload = l0_o_ready;
        k_en  = l0_o_ready;
        if (l0_o_ready && k_last) state_nx = ST_EXEC;
      end
      ST_EXEC: begin
        l0_rd  = l0_o_ready;
        exec_b = l0_o_ready;
        v_en   = l0_o_ready;
        if (l0_o_ready && v_last) state_nx = ST_FLUSH;
      end
      ST_FLUSH: begin
        f_en = 1'b1;
        if (f_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        of_rd  = ofifo_o_valid;
        exec_b = ofifo_o_valid && mode_q;
        d_en   = ofifo_o_valid;
        if (ofifo_o_valid && d_last) state_nx = ST_DONE;
      end
      ST_DONE:  state_nx = ST_IDLE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // every phase counter starts from zero at the beginning of each tile
  assign cnt_clr = (state == ST_IDLE);

  seq_counter #(.CNT_W(CNT_W)) u_kcnt (
    .clk(clk), .reset(reset), .en(k_en), .clr(cnt_clr), .term(K_TERM), .last(k_last)
  );
  seq_counter #(.CNT_W(CNT_W)) u_vcnt (
    .clk(clk), .reset(reset), .en(v_en), .clr(cnt_clr), .term(nv_q), .last(v_last)
  );
  seq_counter #(.CNT_W(CNT_W)) u_fcnt (
    .clk(clk), .reset(reset), .en(f_en), .clr(cnt_clr), .term(F_TERM), .last(f_last)
  );
  seq_counter #(.CNT_W(CNT_W)) u_dcnt (
    .clk(clk), .reset(reset), .en(d_en), .clr(cnt_clr), .term(nv_q), .last(d_last)
  );

  assign host_ready = host_valid && !l0_o_full;
  assign busy       = (state != ST_IDLE);
  assign done       = (state == ST_DONE);

  always_comb begin
    inst          = '0;
    inst[KLOAD]   = kload;
    inst[EXEC]    = exec_b;
    inst[L0_WR]   = host_ready;
    inst[L0_RD]   = l0_rd;
    inst[OF_RD]   = of_rd;
    inst[SFP_ACC] = sfp_q;
  end

endmodule

// File: tb/tb_corelet_seq.sv
// Bench for corelet_seq: a work-remaining reference model predicts every
// cycle's instruction word, busy and done under random handshakes.
module tb_corelet_seq;

  localparam int ROW   = 8;
  localparam int COL   = 8;
  localparam int CNT_W = 8;

  logic             clk, reset, start, mode, acc_en;
  logic [CNT_W-1:0] num_vec;
  logic             l0_o_ready, l0_o_full, ofifo_o_valid, host_valid;
  logic             host_ready, busy, done;
  logic [33:0]      inst;

  corelet_seq #(.ROW(ROW), .COL(COL), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .num_vec(num_vec),
    .acc_en(acc_en), .l0_o_ready(l0_o_ready), .l0_o_full(l0_o_full),
    .ofifo_o_valid(ofifo_o_valid), .host_valid(host_valid),
    .host_ready(host_ready), .inst(inst), .busy(busy), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int t_start, t_done;

  // reference model: outstanding work per phase of the current tile
  bit m_busy, m_mode, m_acc, m_33;
  int m_k, m_v, m_f, m_d;

  task automatic chk(input string tag, input logic [33:0] got, input logic [33:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic tick();
    logic [33:0] e;
    bit eb, ed, n33;
    #1;
    if (reset) begin
      m_busy = 0; m_mode = 0; m_acc = 0; m_33 = 0;
      m_k = 0; m_v = 0; m_f = 0; m_d = 0;
    end
    e = '0;
    e[2]  = host_valid && !l0_o_full;
    e[33] = m_33;
    eb = m_busy; ed = 0; n33 = 0;
    if (reset) begin
    end else if (!m_busy) begin
      if (start) begin
        m_busy = 1; m_mode = mode; m_acc = acc_en;
        m_k = (mode || num_vec == 0) ? 0 : COL;
        m_v = int'(num_vec);
        m_f = (num_vec == 0) ? 0 : ROW + COL;
        m_d = int'(num_vec);
        t_start = cyc;
      end
    end else if (m_k > 0) begin
      e[0] = l0_o_ready; e[3] = l0_o_ready;
      if (l0_o_ready) m_k--;
    end else if (m_v > 0) begin
      e[1] = l0_o_ready; e[3] = l0_o_ready;
      if (l0_o_ready) m_v--;
    end else if (m_f > 0) begin
      m_f--;
    end else if (m_d > 0) begin
      e[6] = ofifo_o_valid;
      e[1] = ofifo_o_valid && m_mode;
      n33  = ofifo_o_valid && m_acc;
      if (ofifo_o_valid) m_d--;
    end else begin
      ed = 1; m_busy = 0;
    end
    chk("inst", inst, e);
    chk("busy", 34'(busy), 34'(eb));
    chk("done", 34'(done), 34'(ed));
    chk("host_ready", 34'(host_ready), 34'(e[2]));
    if (done === 1'b1) t_done = cyc;
    m_33 = n33;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic rand_host();
    host_valid = 1'($urandom_range(0, 1));
    l0_o_full  = 1'($urandom_range(0, 1));
  endtask

  // start a tile, then keep ticking with random handshakes until the model idles
  task automatic run_tile(input bit md, input int nv, input bit acc,
                          input int rdy_pct, input int ov_pct, input bit poke_start);
    int guard;
    start = 1; mode = md; num_vec = CNT_W'(nv); acc_en = acc;
    rand_host();
    tick();
    start = 0;
    guard = 0;
    while (m_busy && guard < 3000) begin
      l0_o_ready    = ($urandom_range(1, 100) <= rdy_pct);
      ofifo_o_valid = ($urandom_range(1, 100) <= ov_pct);
      rand_host();
      if (poke_start) begin
        start   = ($urandom_range(0, 3) == 0);
        mode    = 1'($urandom_range(0, 1));
        num_vec = CNT_W'($urandom_range(0, 255));
        acc_en  = 1'($urandom_range(0, 1));
      end
      tick();
      start = 0;
      guard++;
    end
    chk("tile_timeout", 34'(m_busy), 34'(0));
  endtask

  initial begin
    reset = 1; start = 0; mode = 0; num_vec = '0; acc_en = 0;
    l0_o_ready = 0; l0_o_full = 0; ofifo_o_valid = 0; host_valid = 0;
    m_busy = 0; m_mode = 0; m_acc = 0; m_33 = 0;
    m_k = 0; m_v = 0; m_f = 0; m_d = 0;
    t_start = 0; t_done = -1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rand_host();
      tick();
    end
    reset = 0;
    tick();

    // WS, 4 vectors, everything ready: done on the 34th cycle counting start
    l0_o_ready = 1; ofifo_o_valid = 1; host_valid = 0; l0_o_full = 0;
    start = 1; mode = 0; num_vec = 8'd4; acc_en = 0;
    tick();
    start = 0;
    for (int i = 0; i < 40 && m_busy; i++) tick();
    chk("ws4_done_latency", 34'(t_done - t_start), 34'(33));

    // OS with accumulate
    run_tile(1, 3, 1, 100, 100, 0);

    // EXEC stall pattern 1,0,0,1 with 2 vectors
    l0_o_ready = 1; ofifo_o_valid = 1;
    start = 1; mode = 1; num_vec = 8'd2; acc_en = 0;
    tick();
    start = 0;
    l0_o_ready = 1; tick();
    l0_o_ready = 0; tick();
    l0_o_ready = 0; tick();
    l0_o_ready = 1; tick();
    for (int i = 0; i < 40 && m_busy; i++) tick();
    chk("stall_idle", 34'(m_busy), 34'(0));

    // zero-vector tile
    run_tile(0, 0, 1, 100, 100, 0);

    // reset in DRAIN after one of four reads
    l0_o_ready = 1; ofifo_o_valid = 1;
    start = 1; mode = 0; num_vec = 8'd4; acc_en = 1;
    tick();
    start = 0;
    for (int i = 0; i < 60 && !(m_busy && m_k == 0 && m_v == 0 && m_f == 0 && m_d == 3); i++)
      tick();
    chk("reached_drain", 34'(m_d), 34'(3));
    t_done = -1;
    reset = 1; tick();
    reset = 0;
    run_tile(0, 4, 1, 100, 100, 0);

    // host writes with toggling full and starts poked while busy
    run_tile(0, 3, 0, 100, 100, 1);

    // random tiles, including the full-range vector count
    for (int t = 0; t < 8; t++)
      run_tile(1'($urandom_range(0, 1)), $urandom_range(1, 12), 1'($urandom_range(0, 1)),
               $urandom_range(40, 100), $urandom_range(40, 100), 1);
    run_tile(0, 255, 1, 80, 80, 1);
    run_tile(1, 255, 1, 90, 70, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
